waveform_analyzer: RTL and testbench
====================================

# waveform_analyzer

- Measures the 12-bit unsigned sample stream that the waveform generators produce (midscale 2048 = zero), or a stream fed back from the ADC path.
- Per period it reports:
  - period length in samples, from hysteretic rising midscale crossings;
  - peak max, peak min and peak-to-peak amplitude.
- It sits downstream of the generator/output mux and feeds the display/readback logic and self-test.

## Interface
- SAMPLE_W, 12: sample width.
- MIDSCALE, 2048: zero-level code.
- HYST, 64: hysteresis half-width in codes.
- PERIOD_W, 24: period counter width.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_in  in  SAMPLE_W  unsigned sample.
- sample_valid  in  1  sample_in is accepted this cycle.
- period  out  PERIOD_W  last measured period, in accepted samples.
- vmax  out  SAMPLE_W  maximum sample of the last measured period.
- vmin  out  SAMPLE_W  minimum sample of the last measured period.
- p2p  out  SAMPLE_W  vmax − vmin.
- meas_valid  out  1  one-cycle pulse when period/vmax/vmin/p2p update.
- locked  out  1  at least one measurement published since last reset/timeout.
- timeout  out  1  one-cycle pulse on period-counter saturation.

## Operation
- Thresholds:
  - LO = MIDSCALE−HYST: "below" means sample_in < LO (1984 at defaults).
  - HI = MIDSCALE+HYST: "above" means sample_in ≥ HI (2112 at defaults).
- State is evaluated only on cycles with sample_valid=1. With sample_valid=0 every register holds.
- FSM states and transitions:
  - ACQ_LO: wait for a below sample → ACQ_HI.
  - ACQ_HI: wait for an above sample (the first rising crossing) → HIGH. On that sample: cnt=1, max=min=sample.
  - HIGH: every sample increments cnt and updates max/min. A below sample → LOW.
  - LOW: every non-crossing sample increments cnt and updates max/min. An above sample is a rising crossing, which:
    - publishes period=cnt, vmax=max, vmin=min, p2p=max−min;
    - pulses meas_valid and sets locked;
    - then sets cnt=1 and max=min=crossing sample, and goes → HIGH.
- The crossing sample belongs to the new period, not the one being published. A 50-below/50-above stream therefore gives period=100.
- Samples between LO and HI never change state; they only count and track min/max.
- Saturation:
  - Trigger: an accepted non-crossing sample in HIGH/LOW finds cnt = 2^PERIOD_W−1.
  - Response: pulse timeout, clear locked, go → ACQ_LO.
  - period/vmax/vmin/p2p hold their last values.
- Reset values: FSM=ACQ_LO, cnt=0, period=0, vmax=0, vmin=0, p2p=0, meas_valid=0, locked=0, timeout=0.
- Reset mid-period discards the partial measurement. Reset is asynchronous and takes effect immediately.
- p2p is never negative, because max ≥ min by construction. Width is SAMPLE_W with no sign bit.

## Timing
- All outputs are registered.
- meas_valid, timeout and the updated values appear on the clock edge after the cycle that presents the crossing or saturating sample (latency 1).
- meas_valid and timeout cannot both pulse in the same cycle. A crossing sample takes priority over saturation.
- Throughput: one sample per clock, with no backpressure.

## Configuration
- WAVE_ANALYZER_AVG_EN defined:
  - period is the mean of the last 4 raw periods: 4-entry shift register plus a (PERIOD_W+2)-bit running sum, shifted right by 2 and truncated.
  - meas_valid first pulses on the 4th raw measurement after lock. locked also rises on the 4th measurement.
  - Latency becomes 2 for all outputs, which stay aligned.
  - Timeout or reset clears the history.
- Undefined: raw period, latency 1, as described above.

## Structure
- Shared package wave_pkg holds:
  - the state encoding (ACQ_LO, ACQ_HI, HIGH, LOW);
  - the default SAMPLE_W/MIDSCALE constants, shared with the generators.
- Sub-module period_averager: instantiated only under WAVE_ANALYZER_AVG_EN. It has a raw period/strobe input and an averaged period/strobe output.

## Test plan
- Square stream of 50×1000 then 50×3000, repeated, at sample_valid=1 → meas_valid every 100 samples after the second rising edge; period=100, vmax=3000, vmin=1000, p2p=2000, locked=1.
- Same stream with sample_valid toggling 1,0 → identical period=100, pulses 200 clocks apart.
- Noise alternating 2000/2100 (inside 1984..2111) after lock → no meas_valid. After 2^24−1 samples: timeout pulse, locked=0, outputs hold 100/3000/1000/2000.
- Threshold edges: stream toggling 1984↔2112 → no measurement. Stream toggling 1983↔2112 → period equals the toggle period.
- rst asserted mid-period (asynchronously, between edges) → all outputs 0 immediately. The next measurement requires a below, then above, then a full period.
- With WAVE_ANALYZER_AVG_EN: raw periods 100,100,100,104 → first meas_valid with period=101. The next period of 100 gives 101 (truncated 404/4 = 101).

Source files
------------

// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared waveform constants and analyzer state encoding
package wave_pkg;
    localparam int WAVE_SAMPLE_W = 12;
    localparam int WAVE_MIDSCALE = 2048;
    localparam int WAVE_HYST     = 64;
    localparam int WAVE_PERIOD_W = 24;

    typedef enum logic [1:0] {
        ACQ_LO,
        ACQ_HI,
        HIGH,
        LOW
    } wave_state_e;
endpackage

// File: rtl/waveform_analyzer_if.sv
// rtl/waveform_analyzer_if.sv - sample stream in, period/peak measurements out
interface waveform_analyzer_if #(
    parameter int SAMPLE_W = wave_pkg::WAVE_SAMPLE_W,
    parameter int PERIOD_W = wave_pkg::WAVE_PERIOD_W
);
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic [PERIOD_W-1:0] period;
    logic [SAMPLE_W-1:0] vmax;
    logic [SAMPLE_W-1:0] vmin;
    logic [SAMPLE_W-1:0] p2p;
    logic                meas_valid;
    logic                locked;
    logic                timeout;

    modport master (
        output sample_in, sample_valid,
        input  period, vmax, vmin, p2p, meas_valid, locked, timeout
    );

    modport slave (
        input  sample_in, sample_valid,
        output period, vmax, vmin, p2p, meas_valid, locked, timeout
    );
endinterface

// File: rtl/period_averager.sv
// rtl/period_averager.sv - mean of the last four raw periods, strobed once history is full
module period_averager #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PERIOD_W-1:0] raw_period_i,
    input  logic                raw_valid_i,
    input  logic                clear_i,
    output logic [PERIOD_W-1:0] avg_period_o,
    output logic                avg_valid_o,
    output logic                primed_o
);
    logic [PERIOD_W-1:0] hist_q [4];
    logic [PERIOD_W+1:0] sum_q;
    logic [PERIOD_W+1:0] sum_d;
    logic [2:0]          fill_q;
    logic [PERIOD_W-1:0] avg_q;
    logic                valid_q;

    // Running sum: add the newest period, drop the one falling out of the window.
    assign sum_d    = sum_q + {2'b00, raw_period_i} - {2'b00, hist_q[3]};
    assign primed_o = (fill_q >= 3'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q  <= '{default: '0};
            sum_q   <= '0;
            fill_q  <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (clear_i) begin
                hist_q <= '{default: '0};
                sum_q  <= '0;
                fill_q <= '0;
            end else if (raw_valid_i) begin
                hist_q[0] <= raw_period_i;
                hist_q[1] <= hist_q[0];
                hist_q[2] <= hist_q[1];
                hist_q[3] <= hist_q[2];
                sum_q     <= sum_d;
                if (fill_q != 3'd4) begin
                    fill_q <= fill_q + 3'd1;
                end
                if (primed_o) begin
                    avg_q   <= sum_d[PERIOD_W+1:2];
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign avg_period_o = avg_q;
    assign avg_valid_o  = valid_q;
endmodule

// File: rtl/waveform_analyzer.sv
// rtl/waveform_analyzer.sv - hysteretic period and peak measurement of a sample stream
// Optional WAVE_ANALYZER_AVG_EN: period reported as the mean of the last 4 raw periods.
module waveform_analyzer
    import wave_pkg::*;
#(
    parameter int SAMPLE_W = WAVE_SAMPLE_W,
    parameter int MIDSCALE = WAVE_MIDSCALE,
    parameter int HYST     = WAVE_HYST,
    parameter int PERIOD_W = WAVE_PERIOD_W
) (
    input  logic               clk,
    input  logic               rst,
    waveform_analyzer_if.slave bus
);
    localparam logic [SAMPLE_W-1:0] LO      = SAMPLE_W'(MIDSCALE - HYST);
    localparam logic [SAMPLE_W-1:0] HI      = SAMPLE_W'(MIDSCALE + HYST);
    localparam logic [PERIOD_W-1:0] CNT_MAX = {PERIOD_W{1'b1}};

    wave_state_e         state_q;
    logic [PERIOD_W-1:0] cnt_q, cnt_d, period_q;
    logic [SAMPLE_W-1:0] max_q, max_d, min_q, min_d;
    logic [SAMPLE_W-1:0] vmax_q, vmin_q, p2p_q;
    logic                meas_q, locked_q, timeout_q;
    logic                below, above;

    assign below = (bus.sample_in < LO);
    assign above = (bus.sample_in >= HI);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        max_d = (bus.sample_in > max_q) ? bus.sample_in : max_q;
        min_d = (bus.sample_in < min_q) ? bus.sample_in : min_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACQ_LO;
            cnt_q     <= '0;
            max_q     <= '0;
            min_q     <= '0;
            period_q  <= '0;
            vmax_q    <= '0;
            vmin_q    <= '0;
            p2p_q     <= '0;
            meas_q    <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            meas_q    <= 1'b0;
            timeout_q <= 1'b0;
            if (bus.sample_valid) begin
                case (state_q)
                    ACQ_LO: begin
                        if (below) state_q <= ACQ_HI;
                    end
                    ACQ_HI: begin
                        if (above) begin
                            state_q <= HIGH;
                            cnt_q   <= PERIOD_W'(1);
                            max_q   <= bus.sample_in;
                            min_q   <= bus.sample_in;
                        end
                    end
                    HIGH, LOW: begin
                        // The crossing sample opens the next period, so it is excluded from the published one.
                        if (state_q == LOW && above) begin
                            period_q <= cnt_q;
                            vmax_q   <= max_q;
                            vmin_q   <= min_q;
                            p2p_q    <= max_q - min_q;
                            meas_q   <= 1'b1;
                            locked_q <= 1'b1;
                            state_q  <= HIGH;
                            cnt_q    <= PERIOD_W'(1);
                            max_q    <= bus.sample_in;
                            min_q    <= bus.sample_in;
                        end else if (cnt_q == CNT_MAX) begin
                            timeout_q <= 1'b1;
                            locked_q  <= 1'b0;
                            state_q   <= ACQ_LO;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                            max_q <= max_d;
                            min_q <= min_d;
                            if (state_q == HIGH && below) state_q <= LOW;
                        end
                    end
                    default: state_q <= ACQ_LO;
                endcase
            end
        end
    end

`ifdef WAVE_ANALYZER_AVG_EN
    logic [PERIOD_W-1:0] avg_period;
    logic                avg_valid, avg_primed;
    logic [SAMPLE_W-1:0] vmax_o_q, vmin_o_q, p2p_o_q;
    logic                locked_o_q, timeout_o_q;

    period_averager #(.PERIOD_W(PERIOD_W)) u_avg (
        .clk          (clk),
        .rst          (rst),
        .raw_period_i (period_q),
        .raw_valid_i  (meas_q),
        .clear_i      (timeout_q),
        .avg_period_o (avg_period),
        .avg_valid_o  (avg_valid),
        .primed_o     (avg_primed)
    );

    // Second output stage keeps peaks, lock and timeout aligned with the averaged period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vmax_o_q    <= '0;
            vmin_o_q    <= '0;
            p2p_o_q     <= '0;
            locked_o_q  <= 1'b0;
            timeout_o_q <= 1'b0;
        end else begin
            timeout_o_q <= timeout_q;
            if (timeout_q) begin
                locked_o_q <= 1'b0;
            end else if (meas_q && avg_primed) begin
                locked_o_q <= locked_q;
                vmax_o_q   <= vmax_q;
                vmin_o_q   <= vmin_q;
                p2p_o_q    <= p2p_q;
            end
        end
    end

    assign bus.period     = avg_period;
    assign bus.meas_valid = avg_valid;
    assign bus.vmax       = vmax_o_q;
    assign bus.vmin       = vmin_o_q;
    assign bus.p2p        = p2p_o_q;
    assign bus.locked     = locked_o_q;
    assign bus.timeout    = timeout_o_q;
`else
    assign bus.period     = period_q;
    assign bus.meas_valid = meas_q;
    assign bus.vmax       = vmax_q;
    assign bus.vmin       = vmin_q;
    assign bus.p2p        = p2p_q;
    assign bus.locked     = locked_q;
    assign bus.timeout    = timeout_q;
`endif
endmodule

// File: tb/tb_waveform_analyzer.sv
// tb/tb_waveform_analyzer.sv - scoreboard bench for waveform_analyzer
module tb_waveform_analyzer;
    localparam int SW = 12;
    localparam int PW = 10;
    localparam int CNT_MAX = (1 << PW) - 1;
`ifdef WAVE_ANALYZER_AVG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        bit     is_to;
        int     per;
        int     mx;
        int     mn;
        int     pp;
        longint cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    exp_t   exp_q[$];
    exp_t   mon_e;

    waveform_analyzer_if #(.SAMPLE_W(SW), .PERIOD_W(PW)) bus ();

    waveform_analyzer #(.SAMPLE_W(SW), .PERIOD_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.meas_valid === 1'b1 || bus.timeout === 1'b1) begin
            n_checks++;
            if (bus.meas_valid === 1'b1 && bus.timeout === 1'b1) begin
                n_fail++;
                $display("FAIL both_pulses cycle=%0d meas_valid=1 timeout=1 required=only one", cyc);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse cycle=%0d meas_valid=%0b timeout=%0b period=%0d required=no pulse",
                         cyc, bus.meas_valid, bus.timeout, bus.period);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.timeout !== mon_e.is_to || cyc != mon_e.cyc ||
                    bus.period !== PW'(mon_e.per) || bus.vmax !== SW'(mon_e.mx) ||
                    bus.vmin !== SW'(mon_e.mn) || bus.p2p !== SW'(mon_e.pp)) begin
                    n_fail++;
                    $display("FAIL scoreboard timeout=%0b/%0b cycle=%0d/%0d period=%0d/%0d vmax=%0d/%0d vmin=%0d/%0d p2p=%0d/%0d (actual/required)",
                             bus.timeout, mon_e.is_to, cyc, mon_e.cyc, bus.period, mon_e.per,
                             bus.vmax, mon_e.mx, bus.vmin, mon_e.mn, bus.p2p, mon_e.pp);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog cycle=%0d required=bench completion", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [SW-1:0] s, input logic v);
        bus.sample_in    = s;
        bus.sample_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send('0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_meas(input int per, input int mx, input int mn);
        exp_t e;
        e.is_to = 1'b0; e.per = per; e.mx = mx; e.mn = mn; e.pp = mx - mn; e.cyc = cyc + LAT;
        exp_q.push_back(e);
    endtask

    task automatic push_timeout(input int per, input int mx, input int mn);
        exp_t e;
        e.is_to = 1'b1; e.per = per; e.mx = mx; e.mn = mn; e.pp = mx - mn; e.cyc = cyc + LAT;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [SW-1:0] s, input bit gap);
        send(s, 1'b1);
        if (gap) send('0, 1'b0);
    endtask

    // n_lo samples of 1000 then n_hi of 3000; the first 3000 is a rising crossing.
    task automatic cycle_sq(input int n_lo, input int n_hi, input bit publish, input int per, input bit gap);
        for (int i = 0; i < n_lo; i++) drive(12'd1000, gap);
        if (publish) push_meas(per, 3000, 1000);
        drive(12'd3000, gap);
        for (int i = 1; i < n_hi; i++) drive(12'd3000, gap);
    endtask

    task automatic drain_check(input string name);
        idle(4);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_pulses pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.period !== '0) begin n_fail++; $display("FAIL reset_period actual=%0d required=0", bus.period); end
        n_checks++;
        if (bus.vmax !== '0) begin n_fail++; $display("FAIL reset_vmax actual=%0d required=0", bus.vmax); end
        n_checks++;
        if (bus.vmin !== '0) begin n_fail++; $display("FAIL reset_vmin actual=%0d required=0", bus.vmin); end
        n_checks++;
        if (bus.p2p !== '0) begin n_fail++; $display("FAIL reset_p2p actual=%0d required=0", bus.p2p); end
        n_checks++;
        if (bus.meas_valid !== 1'b0) begin n_fail++; $display("FAIL reset_meas_valid actual=%0b required=0", bus.meas_valid); end
        n_checks++;
        if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked actual=%0b required=0", bus.locked); end
        n_checks++;
        if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout actual=%0b required=0", bus.timeout); end
    endtask

    task automatic test_square();
        do_reset();
        cycle_sq(50, 50, 1'b0, 0, 1'b0);
        for (int r = 0; r < 3; r++) cycle_sq(50, 50, 1'b1, 100, 1'b0);
        drain_check("square");
        n_checks++;
        if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL square_locked actual=%0b required=1", bus.locked); end
    endtask

    task automatic test_valid_toggle();
        do_reset();
        cycle_sq(50, 50, 1'b0, 0, 1'b1);
        for (int r = 0; r < 3; r++) cycle_sq(50, 50, 1'b1, 100, 1'b1);
        drain_check("valid_toggle");
    endtask

    task automatic test_timeout();
        do_reset();
        cycle_sq(50, 50, 1'b0, 0, 1'b0);
        for (int i = 0; i < 50; i++) send(12'd1000, 1'b1);
        push_meas(100, 3000, 1000);
        send(12'd3000, 1'b1);
        for (int k = 1; k <= CNT_MAX; k++) begin
            if (k == CNT_MAX) push_timeout(100, 3000, 1000);
            send((k % 2) ? 12'd2000 : 12'd2100, 1'b1);
        end
        drain_check("timeout");
        n_checks++;
        if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL timeout_locked actual=%0b required=0", bus.locked); end
        n_checks++;
        if (bus.period !== PW'(100) || bus.vmax !== SW'(3000) || bus.vmin !== SW'(1000) || bus.p2p !== SW'(2000)) begin
            n_fail++;
            $display("FAIL timeout_hold period=%0d vmax=%0d vmin=%0d p2p=%0d required=100/3000/1000/2000",
                     bus.period, bus.vmax, bus.vmin, bus.p2p);
        end
    endtask

    task automatic test_thresholds();
        do_reset();
        for (int i = 0; i < 20; i++) send((i % 2) ? 12'd2112 : 12'd1984, 1'b1);
        idle(3);
        n_checks++;
        if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL thresh_1984_locked actual=%0b required=0", bus.locked); end
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 1 && i >= 3) push_meas(2, 2112, 1983);
            send((i % 2) ? 12'd2112 : 12'd1983, 1'b1);
        end
        drain_check("thresh_1983");
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle_sq(50, 50, 1'b0, 0, 1'b0);
        cycle_sq(50, 50, 1'b1, 100, 1'b0);
        for (int i = 0; i < 25; i++) send(12'd1000, 1'b1);
        idle(3);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.period, bus.vmax, bus.vmin, bus.p2p, bus.meas_valid, bus.locked, bus.timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs period=%0d vmax=%0d vmin=%0d p2p=%0d locked=%0b required=all 0",
                     bus.period, bus.vmax, bus.vmin, bus.p2p, bus.locked);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 30; i++) send(12'd3000, 1'b1);
        cycle_sq(50, 50, 1'b0, 0, 1'b0);
        cycle_sq(50, 50, 1'b1, 100, 1'b0);
        drain_check("reset_mid");
    endtask

    task automatic test_avg();
        do_reset();
        cycle_sq(50, 50, 1'b0, 0, 1'b0);
        for (int r = 0; r < 3; r++) cycle_sq(50, 50, 1'b0, 0, 1'b0);
        idle(3);
        n_checks++;
        if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL avg_early_locked actual=%0b required=0", bus.locked); end
        cycle_sq(54, 50, 1'b1, 101, 1'b0);
        cycle_sq(50, 50, 1'b1, 101, 1'b0);
        drain_check("avg");
        n_checks++;
        if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL avg_locked actual=%0b required=1", bus.locked); end
    endtask

    initial begin
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        test_reset();
`ifdef WAVE_ANALYZER_AVG_EN
        test_avg();
`else
        test_square();
        test_valid_toggle();
        test_thresholds();
        test_reset_mid();
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
